id_ex_hazard_stage: RTL and testbench

Second-generation ID/EX boundary for the MIPS pipeline. It registers the decoded ID bundle (operands, immediate, register indices and a parametrised control vector) into the EX stage. It detects load-use and branch-operand hazards against the instruction currently in EX. On a hazard it inserts multi-cycle bubbles through a stall state machine, and it raises the IF/ID flush for taken branches. It sits between the decoder/register file/branch calculator and the execute stage, and also keeps a saturating bubble counter for the debug unit.

---
 rtl/id_ex_hazard_stage_pkg.sv | 47 ++++
 rtl/id_ex_hazard_stage_hazard_detect.sv | 60 ++++++
 rtl/id_ex_hazard_stage.sv | 197 +++++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_hazard_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage_pkg
// Shared definitions for the ID/EX boundary stage:
//   - default control-bundle width and field offsets inside the bundle
//   - FSM state encoding for the stall sequencer
//   - clogb2 helper for sizing index and counter widths
// No ports (package).
// -----------------------------------------------------------------------------
package id_ex_hazard_stage_pkg;

    // Control bundle, MSB first:
    // RegDst | RegWrite | ALUSrc | ALUOp[1:0] | MemRead | MemWrite | MemtoReg | ALUCtrl[3:0]
    localparam int CANT_BITS_CTRL   = 12;
    localparam int CTRL_REGDST      = 11;
    localparam int CTRL_REGWRITE    = 10;
    localparam int CTRL_ALUSRC      = 9;
    localparam int CTRL_ALUOP_HI    = 8;
    localparam int CTRL_ALUOP_LO    = 7;
    localparam int CTRL_MEMREAD     = 6;
    localparam int CTRL_MEMWRITE    = 5;
    localparam int CTRL_MEMTOREG    = 4;
    localparam int CTRL_ALUCTRL_HI  = 3;
    localparam int CTRL_ALUCTRL_LO  = 0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } stage_state_e;

    // Bits needed to hold values 0..value-1; never returns less than 1 so
    // it is always usable as a vector width.
    function automatic int clogb2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage_hazard_detect
// Purely combinational hazard check of the instruction in ID against the
// instruction in EX. Produces the number of bubbles the pair needs.
// Ports:
//   id_rs, id_rt       ID source register indices
//   id_uses_rt         ID instruction actually reads rt
//   id_is_branch       ID instruction resolves in ID (needs operands early)
//   ex_mem_read        EX instruction is a load
//   ex_reg_write       EX instruction writes a register
//   ex_reg_dst         EX destination register index
//   stall_need         bubbles required: 0, 1 or MAX_STALL
// -----------------------------------------------------------------------------
module id_ex_hazard_stage_hazard_detect #(
    parameter int RW        = 5,
    parameter int MAX_STALL = 2,
    parameter int KW        = 2
) (
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rt,
    input  logic          id_is_branch,
    input  logic          ex_mem_read,
    input  logic          ex_reg_write,
    input  logic [RW-1:0] ex_reg_dst,
    output logic [KW-1:0] stall_need
);

    localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_MAX  = KW'(MAX_STALL);
    localparam logic [RW-1:0] R_ZERO = {RW{1'b0}};

    logic hit_rs_s;
    logic hit_rt_s;
    logic hit_s;

    // Register match; $0 is hard-wired so it can never carry a dependency
    always_comb begin
        hit_rs_s = (ex_reg_dst == id_rs) && (id_rs != R_ZERO);
        hit_rt_s = id_uses_rt && (ex_reg_dst == id_rt) && (id_rt != R_ZERO);
        hit_s    = hit_rs_s || hit_rt_s;
    end

    // Bubble demand: a load feeding a branch needs the load to reach WB,
    // an ALU result feeding a branch needs one cycle to leave EX
    always_comb begin
        stall_need = K_ZERO;
        if (ex_mem_read && hit_s && id_is_branch) begin
            stall_need = K_MAX;
        end else if (ex_mem_read && hit_s) begin
            stall_need = K_ONE;
        end else if (ex_reg_write && hit_s && id_is_branch) begin
            stall_need = K_ONE;
        end else begin
            stall_need = K_ZERO;
        end
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage
// ID/EX pipeline register with load-use / branch-operand hazard handling.
// A hazard inserts one or more bubbles (all-zero EX bundle) through a small
// RUN/STALL sequencer; taken branches flush IF/ID unless the stage stalls.
// A saturating counter reports how many bubbles were inserted.
// Ports:
//   i_clock, i_soft_reset       clock, synchronous active-high reset
//   i_enable_pipeline           global step enable; low freezes everything
//   i_id_rs/rt/rd, i_id_uses_rt, i_id_is_branch   ID register usage
//   i_id_data_A/B, i_id_imm, i_id_ctrl            ID payload
//   i_ex_mem_read, i_ex_reg_write, i_ex_reg_dst   instruction currently in EX
//   i_branch_taken              branch decision for the ID instruction
//   o_ex_*                      registered EX bundle (ctrl == 0 is a bubble)
//   o_stall, o_flush_if_id      combinational PC/IF-ID hold and IF/ID flush
//   o_bubble_count              saturating bubble count
// -----------------------------------------------------------------------------
module id_ex_hazard_stage #(
    parameter int CANT_REGISTROS      = 32,
    parameter int CANT_BITS_REGISTROS = 32,
    parameter int CANT_BITS_CTRL      = id_ex_hazard_stage_pkg::CANT_BITS_CTRL,
    parameter int MAX_STALL           = 2,
    parameter int CANT_BITS_CONTADOR  = 16,
    localparam int RW = id_ex_hazard_stage_pkg::clogb2(CANT_REGISTROS)
) (
    input  logic                           i_clock,
    input  logic                           i_soft_reset,
    input  logic                           i_enable_pipeline,
    input  logic [RW-1:0]                  i_id_rs,
    input  logic [RW-1:0]                  i_id_rt,
    input  logic [RW-1:0]                  i_id_rd,
    input  logic                           i_id_uses_rt,
    input  logic                           i_id_is_branch,
    input  logic [CANT_BITS_REGISTROS-1:0] i_id_data_A,
    input  logic [CANT_BITS_REGISTROS-1:0] i_id_data_B,
    input  logic [CANT_BITS_REGISTROS-1:0] i_id_imm,
    input  logic [CANT_BITS_CTRL-1:0]      i_id_ctrl,
    input  logic                           i_ex_mem_read,
    input  logic                           i_ex_reg_write,
    input  logic [RW-1:0]                  i_ex_reg_dst,
    input  logic                           i_branch_taken,
    output logic [RW-1:0]                  o_ex_rs,
    output logic [RW-1:0]                  o_ex_rt,
    output logic [RW-1:0]                  o_ex_rd,
    output logic [CANT_BITS_REGISTROS-1:0] o_ex_data_A,
    output logic [CANT_BITS_REGISTROS-1:0] o_ex_data_B,
    output logic [CANT_BITS_REGISTROS-1:0] o_ex_imm,
    output logic [CANT_BITS_CTRL-1:0]      o_ex_ctrl,
    output logic                           o_stall,
    output logic                           o_flush_if_id,
    output logic [CANT_BITS_CONTADOR-1:0]  o_bubble_count
);

    import id_ex_hazard_stage_pkg::*;

    localparam int KW = clogb2(MAX_STALL + 1);
    localparam int W  = CANT_BITS_REGISTROS;
    localparam int CW = CANT_BITS_CTRL;
    localparam int CB = CANT_BITS_CONTADOR;

    localparam logic [KW-1:0] K_ZERO  = {KW{1'b0}};
    localparam logic [KW-1:0] K_ONE   = KW'(1);
    localparam logic [CB-1:0] CNT_ONE = CB'(1);
    localparam logic [CB-1:0] CNT_MAX = {CB{1'b1}};

    stage_state_e      state_r;
    stage_state_e      next_state_s;
    logic [KW-1:0]     rem_r;
    logic [KW-1:0]     next_rem_s;
    logic [KW-1:0]     stall_need_s;
    logic              bubble_s;
    logic              load_s;
    logic              stall_s;
    logic              flush_s;

    logic [RW-1:0]     ex_rs_r;
    logic [RW-1:0]     ex_rt_r;
    logic [RW-1:0]     ex_rd_r;
    logic [W-1:0]      ex_data_a_r;
    logic [W-1:0]      ex_data_b_r;
    logic [W-1:0]      ex_imm_r;
    logic [CW-1:0]     ex_ctrl_r;
    logic [CB-1:0]     bubble_count_r;

    id_ex_hazard_stage_hazard_detect #(
        .RW        (RW),
        .MAX_STALL (MAX_STALL),
        .KW        (KW)
    ) u_hazard_detect (
        .id_rs        (i_id_rs),
        .id_rt        (i_id_rt),
        .id_uses_rt   (i_id_uses_rt),
        .id_is_branch (i_id_is_branch),
        .ex_mem_read  (i_ex_mem_read),
        .ex_reg_write (i_ex_reg_write),
        .ex_reg_dst   (i_ex_reg_dst),
        .stall_need   (stall_need_s)
    );

    // Stall sequencer: next state, bubble/load selection, stall and flush
    always_comb begin
        next_state_s = state_r;
        next_rem_s   = rem_r;
        bubble_s     = 1'b0;
        load_s       = 1'b0;
        stall_s      = 1'b0;
        if (i_enable_pipeline) begin
            case (state_r)
                ST_RUN: begin
                    if (stall_need_s == K_ZERO) begin
                        load_s = 1'b1;
                    end else begin
                        stall_s  = 1'b1;
                        bubble_s = 1'b1;
                        // The current bubble is the first one; the rest are
                        // owed by STALL without re-checking the hazard.
                        if (stall_need_s > K_ONE) begin
                            next_state_s = ST_STALL;
                            next_rem_s   = stall_need_s - K_ONE;
                        end else begin
                            next_state_s = ST_RUN;
                        end
                    end
                end
                ST_STALL: begin
                    stall_s    = 1'b1;
                    bubble_s   = 1'b1;
                    next_rem_s = rem_r - K_ONE;
                    if (rem_r == K_ONE) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_STALL;
                    end
                end
                default: begin
                    next_state_s = ST_RUN;
                    next_rem_s   = K_ZERO;
                end
            endcase
        end else begin
            next_state_s = state_r;
        end
        // A stalled branch is re-decided once its operands are valid
        flush_s = i_branch_taken && !stall_s && i_enable_pipeline;
    end

    // Sequencer state, EX bundle and bubble counter
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state_r        <= ST_RUN;
            rem_r          <= K_ZERO;
            ex_rs_r        <= {RW{1'b0}};
            ex_rt_r        <= {RW{1'b0}};
            ex_rd_r        <= {RW{1'b0}};
            ex_data_a_r    <= {W{1'b0}};
            ex_data_b_r    <= {W{1'b0}};
            ex_imm_r       <= {W{1'b0}};
            ex_ctrl_r      <= {CW{1'b0}};
            bubble_count_r <= {CB{1'b0}};
        end else if (i_enable_pipeline) begin
            state_r <= next_state_s;
            rem_r   <= next_rem_s;
            if (bubble_s) begin
                ex_rs_r     <= {RW{1'b0}};
                ex_rt_r     <= {RW{1'b0}};
                ex_rd_r     <= {RW{1'b0}};
                ex_data_a_r <= {W{1'b0}};
                ex_data_b_r <= {W{1'b0}};
                ex_imm_r    <= {W{1'b0}};
                ex_ctrl_r   <= {CW{1'b0}};
                if (bubble_count_r != CNT_MAX) begin
                    bubble_count_r <= bubble_count_r + CNT_ONE;
                end
            end else if (load_s) begin
                ex_rs_r     <= i_id_rs;
                ex_rt_r     <= i_id_rt;
                ex_rd_r     <= i_id_rd;
                ex_data_a_r <= i_id_data_A;
                ex_data_b_r <= i_id_data_B;
                ex_imm_r    <= i_id_imm;
                ex_ctrl_r   <= i_id_ctrl;
            end
        end
    end

    assign o_ex_rs        = ex_rs_r;
    assign o_ex_rt        = ex_rt_r;
    assign o_ex_rd        = ex_rd_r;
    assign o_ex_data_A    = ex_data_a_r;
    assign o_ex_data_B    = ex_data_b_r;
    assign o_ex_imm       = ex_imm_r;
    assign o_ex_ctrl      = ex_ctrl_r;
    assign o_stall        = stall_s;
    assign o_flush_if_id  = flush_s;
    assign o_bubble_count = bubble_count_r;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard_stage
// Self-checking bench: a vector table of single-cycle hazard cases, hand
// sequences for the multi-cycle corners, and randomized traffic compared
// against a reference model that tracks "bubbles still owed" directly.
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

    localparam int RW = 5;
    localparam int W  = 32;
    localparam int CW = 12;
    localparam int MS = 2;
    localparam int CB = 4;
    localparam int CNT_SAT = 15;

    logic          clk;
    logic          rst;
    logic          en;
    logic [RW-1:0] id_rs, id_rt, id_rd, ex_dst;
    logic          uses_rt, is_br, ex_mr, ex_rw, taken;
    logic [W-1:0]  da, db, imm;
    logic [CW-1:0] ctrl;

    logic [RW-1:0] o_rs, o_rt, o_rd;
    logic [W-1:0]  o_a, o_b, o_imm;
    logic [CW-1:0] o_ctrl;
    logic          o_stall, o_flush;
    logic [CB-1:0] o_cnt;

    int n_checks;
    int n_errors;

    // reference model
    int            m_pend;
    int            m_cnt;
    logic [RW-1:0] m_rs, m_rt, m_rd;
    logic [W-1:0]  m_a, m_b, m_imm;
    logic [CW-1:0] m_ctrl;
    logic          s_stall, s_flush;

    id_ex_hazard_stage #(
        .CANT_REGISTROS      (32),
        .CANT_BITS_REGISTROS (W),
        .CANT_BITS_CTRL      (CW),
        .MAX_STALL           (MS),
        .CANT_BITS_CONTADOR  (CB)
    ) dut (
        .i_clock           (clk),
        .i_soft_reset      (rst),
        .i_enable_pipeline (en),
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_id_rd           (id_rd),
        .i_id_uses_rt      (uses_rt),
        .i_id_is_branch    (is_br),
        .i_id_data_A       (da),
        .i_id_data_B       (db),
        .i_id_imm          (imm),
        .i_id_ctrl         (ctrl),
        .i_ex_mem_read     (ex_mr),
        .i_ex_reg_write    (ex_rw),
        .i_ex_reg_dst      (ex_dst),
        .i_branch_taken    (taken),
        .o_ex_rs           (o_rs),
        .o_ex_rt           (o_rt),
        .o_ex_rd           (o_rd),
        .o_ex_data_A       (o_a),
        .o_ex_data_B       (o_b),
        .o_ex_imm          (o_imm),
        .o_ex_ctrl         (o_ctrl),
        .o_stall           (o_stall),
        .o_flush_if_id     (o_flush),
        .o_bubble_count    (o_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bubbles demanded by the current ID/EX pair, straight from the rules
    function automatic int need_k();
        bit hit;
        hit = ((ex_dst == id_rs) && (id_rs != 0)) ||
              (uses_rt && (ex_dst == id_rt) && (id_rt != 0));
        if (!hit) return 0;
        if (ex_mr) return is_br ? MS : 1;
        if (ex_rw && is_br) return 1;
        return 0;
    endfunction

    task automatic model_bubble();
        m_rs = '0; m_rt = '0; m_rd = '0;
        m_a = '0; m_b = '0; m_imm = '0; m_ctrl = '0;
        if (m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model,
    // check registered outputs just after the edge.
    task automatic cycle();
        int  kk;
        logic e_stall, e_flush;
        #4;
        kk      = need_k();
        e_stall = en && ((m_pend > 0) || (kk > 0));
        e_flush = taken && !e_stall && en;
        s_stall = o_stall;
        s_flush = o_flush;
        if (!rst) begin
            chk("o_stall", o_stall, e_stall);
            chk("o_flush_if_id", o_flush, e_flush);
        end
        if (rst) begin
            m_pend = 0;
            m_cnt  = 0;
            m_rs = '0; m_rt = '0; m_rd = '0;
            m_a = '0; m_b = '0; m_imm = '0; m_ctrl = '0;
        end else if (en) begin
            if (m_pend > 0) begin
                model_bubble();
                m_pend = m_pend - 1;
            end else if (kk > 0) begin
                model_bubble();
                m_pend = kk - 1;
            end else begin
                m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
                m_a = da; m_b = db; m_imm = imm; m_ctrl = ctrl;
            end
        end
        @(posedge clk);
        #1;
        chk("o_ex_rs", o_rs, m_rs);
        chk("o_ex_rt", o_rt, m_rt);
        chk("o_ex_rd", o_rd, m_rd);
        chk("o_ex_data_A", o_a, m_a);
        chk("o_ex_data_B", o_b, m_b);
        chk("o_ex_imm", o_imm, m_imm);
        chk("o_ex_ctrl", o_ctrl, m_ctrl);
        chk("o_bubble_count", o_cnt, m_cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic set_ex(input logic mr, input logic rw, input logic [RW-1:0] dst);
        ex_mr = mr; ex_rw = rw; ex_dst = dst;
    endtask

    task automatic set_id(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rd, input logic uses, input logic br,
                          input logic tk, input logic [CW-1:0] c);
        id_rs = rs; id_rt = rt; id_rd = rd;
        uses_rt = uses; is_br = br; taken = tk; ctrl = c;
        da = $urandom; db = $urandom; imm = $urandom;
    endtask

    typedef struct {
        logic          mr;
        logic          rw;
        logic [RW-1:0] dst;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          uses;
        logic          br;
        logic          tk;
        logic          e_stall;
        logic          e_flush;
    } vec_t;

    vec_t vecs[12];

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_pend = 0; m_cnt = 0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        m_a = '0; m_b = '0; m_imm = '0; m_ctrl = '0;
        rst = 1'b1; en = 1'b1;
        set_ex(1'b0, 1'b0, 5'd0);
        set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 12'h000);

        //             mr    rw    dst    rs     rt     uses  br    tk    stall flush
        vecs[0]  = '{1'b0, 1'b0, 5'd2, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 5'd2, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 5'd2, 5'd4, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 5'd2, 5'd4, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 5'd7, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 5'd2, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 5'd5, 5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        // reset state
        cycle();
        rst = 1'b0;
        chk("reset o_ex_ctrl", o_ctrl, 12'h000);
        chk("reset o_ex_data_A", o_a, 32'h0);
        chk("reset o_bubble_count", o_cnt, 4'd0);

        // single-cycle hazard table, each from a fresh RUN state
        for (int i = 0; i < 12; i++) begin
            do_reset();
            set_ex(vecs[i].mr, vecs[i].rw, vecs[i].dst);
            set_id(vecs[i].rs, vecs[i].rt, 5'd9, vecs[i].uses, vecs[i].br, vecs[i].tk, 12'hABC);
            cycle();
            chk($sformatf("vec%0d stall", i), s_stall, vecs[i].e_stall);
            chk($sformatf("vec%0d flush", i), s_flush, vecs[i].e_flush);
            chk($sformatf("vec%0d ctrl", i), o_ctrl, vecs[i].e_stall ? 12'h000 : 12'hABC);
        end

        // lw $2 ; add $3,$2,$4 -> one bubble, then the add is latched
        do_reset();
        set_ex(1'b1, 1'b1, 5'd2);
        set_id(5'd2, 5'd4, 5'd3, 1'b1, 1'b0, 1'b0, 12'h4C2);
        cycle();
        chk("lu stall1", s_stall, 1'b1);
        chk("lu bubble", o_ctrl, 12'h000);
        set_ex(1'b0, 1'b0, 5'd0);
        cycle();
        chk("lu stall2", s_stall, 1'b0);
        chk("lu add ctrl", o_ctrl, 12'h4C2);
        chk("lu add rd", o_rd, 5'd3);
        chk("lu count", o_cnt, 4'd1);

        // lw $2 ; beq $2,$5 taken -> two bubbles, no flush until cycle 3
        do_reset();
        set_ex(1'b1, 1'b1, 5'd2);
        set_id(5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 12'h021);
        cycle();
        chk("lb stall c1", s_stall, 1'b1);
        chk("lb flush c1", s_flush, 1'b0);
        set_ex(1'b0, 1'b0, 5'd0);
        cycle();
        chk("lb stall c2", s_stall, 1'b1);
        chk("lb flush c2", s_flush, 1'b0);
        cycle();
        chk("lb stall c3", s_stall, 1'b0);
        chk("lb flush c3", s_flush, 1'b1);
        chk("lb count", o_cnt, 4'd2);

        // add $7 ; jr $7 -> one bubble ; with dst $0 -> none
        do_reset();
        set_ex(1'b0, 1'b1, 5'd7);
        set_id(5'd7, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 12'h300);
        cycle();
        chk("jr stall", s_stall, 1'b1);
        set_ex(1'b0, 1'b0, 5'd0);
        cycle();
        chk("jr resume", s_stall, 1'b0);
        chk("jr count", o_cnt, 4'd1);
        do_reset();
        set_ex(1'b0, 1'b1, 5'd0);
        set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 12'h300);
        cycle();
        chk("jr r0 stall", s_stall, 1'b0);
        chk("jr r0 count", o_cnt, 4'd0);

        // hazard held while the pipeline is disabled for three cycles
        do_reset();
        set_ex(1'b0, 1'b0, 5'd0);
        set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 12'h155);
        cycle();
        set_ex(1'b1, 1'b1, 5'd1);
        set_id(5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 12'h2AA);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("dis stall", s_stall, 1'b0);
            chk("dis flush", s_flush, 1'b0);
            chk("dis hold ctrl", o_ctrl, 12'h155);
            chk("dis count", o_cnt, 4'd0);
        end
        en = 1'b1;
        cycle();
        chk("en stall", s_stall, 1'b1);
        chk("en flush", s_flush, 1'b0);
        chk("en bubble", o_ctrl, 12'h000);
        chk("en count", o_cnt, 4'd1);

        // reset during the first bubble of a load+branch stall
        do_reset();
        set_ex(1'b1, 1'b1, 5'd2);
        set_id(5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 12'h021);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rs ctrl", o_ctrl, 12'h000);
        chk("rs rs", o_rs, 5'd0);
        chk("rs count", o_cnt, 4'd0);
        set_ex(1'b0, 1'b0, 5'd0);
        set_id(5'd6, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 12'h7E1);
        cycle();
        chk("rs run stall", s_stall, 1'b0);
        chk("rs run ctrl", o_ctrl, 12'h7E1);
        chk("rs run rs", o_rs, 5'd6);

        // 2^4 + 3 bubbles: counter saturates at 15
        do_reset();
        set_ex(1'b1, 1'b0, 5'd3);
        set_id(5'd3, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 12'h0F0);
        for (int i = 0; i < 19; i++) begin
            cycle();
            if (i == 14) chk("sat at 15", o_cnt, 4'd15);
        end
        chk("sat hold", o_cnt, 4'd15);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 9) != 0);
            set_ex(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)));
            set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 12'($urandom));
            cycle();
        end
        rst = 1'b0;
        en  = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
